// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - start/busy/done handshake and operand/result bundle for serial_adder (Sub under SERIAL_ADDER_SUB_EN)
`timescale 1ns/1ps
interface serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             Start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             CarryIn;
`ifdef SERIAL_ADDER_SUB_EN
    logic             Sub;
`endif
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Sum;
    logic             Carry;
    logic             Overflow;

    modport master (
        output Start, A, B, CarryIn,
`ifdef SERIAL_ADDER_SUB_EN
        output Sub,
`endif
        input  Busy, Done, Sum, Carry, Overflow
    );

    modport slave (
        input  Start, A, B, CarryIn,
`ifdef SERIAL_ADDER_SUB_EN
        input  Sub,
`endif
        output Busy, Done, Sum, Carry, Overflow
    );
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - multi-cycle adder, SLICE bits per clock LSB first; SERIAL_ADDER_SUB_EN adds subtract mode
`timescale 1ns/1ps
module serial_adder #(
    parameter int WIDTH = 16,
    parameter int SLICE = 1
) (
    input  logic          Clk,
    input  logic          Rst_n,
    serial_adder_if.slave bus
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    if (SLICE < 1 || WIDTH < 2 || (WIDTH % SLICE) != 0) begin : g_bad_cfg
        $error("serial_adder: WIDTH must be >= 2 and a multiple of SLICE");
    end

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic             c_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             ovf_q;

    logic [WIDTH-1:0] b_cap;
    logic             c_cap;
    logic [SLICE-1:0] slice_sum;
    logic             c_chain;
    logic             c_msb_in;
    logic             slice_cout;
    logic [WIDTH-1:0] acc_d;

    // Subtraction is folded into the captured operands so the datapath only ever adds.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_cap = bus.Sub ? ~bus.B : bus.B;
    assign c_cap = bus.Sub ? ~bus.CarryIn : bus.CarryIn;
`else
    assign b_cap = bus.B;
    assign c_cap = bus.CarryIn;
`endif

    // c_msb_in is the carry into the top bit of the slice; on the last slice that is bit WIDTH-1.
    always_comb begin
        slice_sum = '0;
        c_chain   = c_q;
        c_msb_in  = c_q;
        for (int i = 0; i < SLICE; i++) begin
            if (i == SLICE - 1) begin
                c_msb_in = c_chain;
            end
            slice_sum[i] = a_q[i] ^ b_q[i] ^ c_chain;
            c_chain      = (a_q[i] & b_q[i]) | (c_chain & (a_q[i] ^ b_q[i]));
        end
        slice_cout = c_chain;
    end

    if (NSLICE == 1) begin : g_acc_single
        assign acc_d = slice_sum;
    end else begin : g_acc_shift
        assign acc_d = {slice_sum, acc_q[WIDTH-1:SLICE]};
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.Start) begin
                        a_q     <= bus.A;
                        b_q     <= b_cap;
                        c_q     <= c_cap;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_q   <= a_q >> SLICE;
                    b_q   <= b_q >> SLICE;
                    c_q   <= slice_cout;
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        sum_q   <= acc_d;
                        carry_q <= slice_cout;
                        ovf_q   <= c_msb_in ^ slice_cout;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.Busy     = busy_q;
    assign bus.Done     = done_q;
    assign bus.Sum      = sum_q;
    assign bus.Carry    = carry_q;
    assign bus.Overflow = ovf_q;
endmodule
